// File: rtl/ps2_scancode_matrix.sv
// Builds the ZX Spectrum 8x5 key matrix from decoded PS/2 set-2 events and serves
// ULA row reads. Also flags Ctrl+Alt+Del and events lost to a full pending slot.
module ps2_scancode_matrix #(
  parameter bit CLEAR_ON_BAT = 1'b1,
  parameter bit DEL_RESET    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_interrupt,
  input  logic [7:0] scancode,
  input  logic       released,
  input  logic       extended,
  input  logic [7:0] addr,
  output logic [4:0] keycol,
  output logic       kbd_reset_req,
  output logic       overrun
);

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 5;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_APPLY} state_t;
  typedef enum logic [2:0] {K_NONE, K_BASE, K_CS, K_SS, K_COMP, K_ALT, K_DEL, K_BAT} kind_t;

  state_t                      r_state;
  logic [7:0]                  r_code;
  logic                        r_rel;
  logic                        r_ext;
  logic                        r_pend_vld;
  logic [7:0]                  r_pend_code;
  logic                        r_pend_rel;
  logic                        r_pend_ext;
  kind_t                       r_kind;
  logic [2:0]                  r_row;
  logic [2:0]                  r_col;
  logic [2:0]                  r_sub;
  logic [ROWS-1:0][COLS-1:0]   r_base;
  logic [1:0]                  r_cs;
  logic [1:0]                  r_ss;
  logic [4:0]                  r_comp;
  logic                        r_alt;
  logic                        r_kbd_reset_req;
  logic                        r_overrun;

  kind_t                       w_kind;
  logic [2:0]                  w_row;
  logic [2:0]                  w_col;
  logic [2:0]                  w_sub;
  logic [6:0]                  w_pos;
  logic [ROWS-1:0][COLS-1:0]   w_eff;
  logic [COLS-1:0]             w_keycol;

  // {valid, row, col} of a plain (non-E0) key that maps to one matrix cell
  function automatic logic [6:0] base_pos(input logic [7:0] code);
    case (code)
      8'h1A: base_pos = {1'b1, 3'd0, 3'd1};
      8'h22: base_pos = {1'b1, 3'd0, 3'd2};
      8'h21: base_pos = {1'b1, 3'd0, 3'd3};
      8'h2A: base_pos = {1'b1, 3'd0, 3'd4};
      8'h1C: base_pos = {1'b1, 3'd1, 3'd0};
      8'h1B: base_pos = {1'b1, 3'd1, 3'd1};
      8'h23: base_pos = {1'b1, 3'd1, 3'd2};
      8'h2B: base_pos = {1'b1, 3'd1, 3'd3};
      8'h34: base_pos = {1'b1, 3'd1, 3'd4};
      8'h15: base_pos = {1'b1, 3'd2, 3'd0};
      8'h1D: base_pos = {1'b1, 3'd2, 3'd1};
      8'h24: base_pos = {1'b1, 3'd2, 3'd2};
      8'h2D: base_pos = {1'b1, 3'd2, 3'd3};
      8'h2C: base_pos = {1'b1, 3'd2, 3'd4};
      8'h16: base_pos = {1'b1, 3'd3, 3'd0};
      8'h1E: base_pos = {1'b1, 3'd3, 3'd1};
      8'h26: base_pos = {1'b1, 3'd3, 3'd2};
      8'h25: base_pos = {1'b1, 3'd3, 3'd3};
      8'h2E: base_pos = {1'b1, 3'd3, 3'd4};
      8'h45: base_pos = {1'b1, 3'd4, 3'd0};
      8'h46: base_pos = {1'b1, 3'd4, 3'd1};
      8'h3E: base_pos = {1'b1, 3'd4, 3'd2};
      8'h3D: base_pos = {1'b1, 3'd4, 3'd3};
      8'h36: base_pos = {1'b1, 3'd4, 3'd4};
      8'h4D: base_pos = {1'b1, 3'd5, 3'd0};
      8'h44: base_pos = {1'b1, 3'd5, 3'd1};
      8'h43: base_pos = {1'b1, 3'd5, 3'd2};
      8'h3C: base_pos = {1'b1, 3'd5, 3'd3};
      8'h35: base_pos = {1'b1, 3'd5, 3'd4};
      8'h5A: base_pos = {1'b1, 3'd6, 3'd0};
      8'h4B: base_pos = {1'b1, 3'd6, 3'd1};
      8'h42: base_pos = {1'b1, 3'd6, 3'd2};
      8'h3B: base_pos = {1'b1, 3'd6, 3'd3};
      8'h33: base_pos = {1'b1, 3'd6, 3'd4};
      8'h29: base_pos = {1'b1, 3'd7, 3'd0};
      8'h3A: base_pos = {1'b1, 3'd7, 3'd2};
      8'h31: base_pos = {1'b1, 3'd7, 3'd3};
      8'h32: base_pos = {1'b1, 3'd7, 3'd4};
      default: base_pos = 7'd0;
    endcase
  endfunction

  // Classify the captured event; modifiers and composites live outside base
  always_comb begin
    w_kind = K_NONE;
    w_row  = 3'd0;
    w_col  = 3'd0;
    w_sub  = 3'd0;
    w_pos  = base_pos(r_code);
    if (!r_ext && w_pos[6]) begin
      w_kind = K_BASE;
      w_row  = w_pos[5:3];
      w_col  = w_pos[2:0];
    end else begin
      case ({r_ext, r_code})
        9'h012: begin w_kind = K_CS;   w_sub = 3'd0; end
        9'h059: begin w_kind = K_CS;   w_sub = 3'd1; end
        9'h014: begin w_kind = K_SS;   w_sub = 3'd0; end
        9'h114: begin w_kind = K_SS;   w_sub = 3'd1; end
        9'h175: begin w_kind = K_COMP; w_sub = 3'd0; end
        9'h172: begin w_kind = K_COMP; w_sub = 3'd1; end
        9'h16B: begin w_kind = K_COMP; w_sub = 3'd2; end
        9'h174: begin w_kind = K_COMP; w_sub = 3'd3; end
        9'h066: begin w_kind = K_COMP; w_sub = 3'd4; end
        9'h011, 9'h111: w_kind = K_ALT;
        9'h071, 9'h171: w_kind = K_DEL;
        9'h0AA: w_kind = K_BAT;
        default: w_kind = K_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_code          <= 8'd0;
      r_rel           <= 1'b0;
      r_ext           <= 1'b0;
      r_pend_vld      <= 1'b0;
      r_pend_code     <= 8'd0;
      r_pend_rel      <= 1'b0;
      r_pend_ext      <= 1'b0;
      r_kind          <= K_NONE;
      r_row           <= 3'd0;
      r_col           <= 3'd0;
      r_sub           <= 3'd0;
      r_base          <= '0;
      r_cs            <= 2'd0;
      r_ss            <= 2'd0;
      r_comp          <= 5'd0;
      r_alt           <= 1'b0;
      r_kbd_reset_req <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_kbd_reset_req <= 1'b0;
      r_overrun       <= 1'b0;
      // Busy FSM: park a new event in the single pending slot or drop it
      if (kb_interrupt && (r_state != S_IDLE)) begin
        if (!r_pend_vld) begin
          r_pend_vld  <= 1'b1;
          r_pend_code <= scancode;
          r_pend_rel  <= released;
          r_pend_ext  <= extended;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend_vld) begin
            r_code  <= r_pend_code;
            r_rel   <= r_pend_rel;
            r_ext   <= r_pend_ext;
            r_state <= S_LOOKUP;
            if (kb_interrupt) begin
              r_pend_code <= scancode;
              r_pend_rel  <= released;
              r_pend_ext  <= extended;
            end else begin
              r_pend_vld <= 1'b0;
            end
          end else if (kb_interrupt) begin
            r_code  <= scancode;
            r_rel   <= released;
            r_ext   <= extended;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_kind          <= w_kind;
          r_row           <= w_row;
          r_col           <= w_col;
          r_sub           <= w_sub;
          r_kbd_reset_req <= DEL_RESET && (w_kind == K_DEL) && !r_rel && (|r_ss) && r_alt;
          r_state         <= S_APPLY;
        end
        S_APPLY: begin
          case (r_kind)
            K_BASE: r_base[r_row][r_col] <= !r_rel;
            K_CS:   r_cs[r_sub[0]]       <= !r_rel;
            K_SS:   r_ss[r_sub[0]]       <= !r_rel;
            K_COMP: r_comp[r_sub]        <= !r_rel;
            K_ALT:  r_alt                <= !r_rel;
            K_BAT: begin
              if (CLEAR_ON_BAT && !r_rel) begin
                r_base <= '0;
                r_cs   <= 2'd0;
                r_ss   <= 2'd0;
                r_comp <= 5'd0;
                r_alt  <= 1'b0;
              end
            end
            default: ;
          endcase
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Effective matrix: composites add their digit plus CS; shift/ctrl sources collapse
  always_comb begin
    w_eff       = r_base;
    w_eff[0][0] = (|r_cs) | (|r_comp);
    w_eff[7][1] = |r_ss;
    w_eff[4][3] = r_base[4][3] | r_comp[0];
    w_eff[4][4] = r_base[4][4] | r_comp[1];
    w_eff[3][4] = r_base[3][4] | r_comp[2];
    w_eff[4][2] = r_base[4][2] | r_comp[3];
    w_eff[4][0] = r_base[4][0] | r_comp[4];
    w_keycol    = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_eff[r][c] && !addr[r]) w_keycol[c] = 1'b0;
      end
    end
  end

  assign keycol        = w_keycol;
  assign kbd_reset_req = r_kbd_reset_req;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_ps2_scancode_matrix.sv
// Bench for ps2_scancode_matrix: a held-key model derives the expected matrix,
// checked every cycle, plus hand-computed literal expectations.
module tb_ps2_scancode_matrix;

  logic       clk;
  logic       rst_n;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       released;
  logic       extended;
  logic [7:0] addr;
  logic [4:0] keycol;
  logic       kbd_reset_req;
  logic       overrun;

  ps2_scancode_matrix dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kb_interrupt (kb_interrupt),
    .scancode     (scancode),
    .released     (released),
    .extended     (extended),
    .addr         (addr),
    .keycol       (keycol),
    .kbd_reset_req(kbd_reset_req),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spectrum layout, row-major; 000 marks the CS and SS cells handled separately
  logic [8:0] layout [40] = '{
    9'h000, 9'h01A, 9'h022, 9'h021, 9'h02A,
    9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
    9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
    9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,
    9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,
    9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,
    9'h029, 9'h000, 9'h03A, 9'h031, 9'h032};
  logic [8:0] comp_key  [5] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h066};
  int         comp_cell [5] = '{23, 24, 19, 22, 20};

  typedef struct {
    logic [8:0] key;
    logic       rel;
    int         due;
  } ev_t;

  bit    held [512];
  ev_t   q [$];
  int    cyc;
  bit    exp_rst;
  bit    exp_ovr;
  int    tx_lat;

  int    n_cmp;
  int    n_bad;
  int    n_rst_seen;
  int    n_ovr_seen;
  bit    lit_en;
  int    lit_sel;
  int    lit_exp;
  string lit_name;

  function automatic bit comp_any();
    bit a = 1'b0;
    for (int k = 0; k < 5; k++) if (held[comp_key[k]]) a = 1'b1;
    return a;
  endfunction

  function automatic bit cell_on(int idx);
    bit on;
    if (idx == 0)  return held[9'h012] | held[9'h059] | comp_any();
    if (idx == 36) return held[9'h014] | held[9'h114];
    on = held[layout[idx]];
    for (int k = 0; k < 5; k++) if (comp_cell[k] == idx && held[comp_key[k]]) on = 1'b1;
    return on;
  endfunction

  function automatic logic [4:0] model_keycol(logic [7:0] a);
    logic [4:0] res = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && cell_on(r * 5 + c)) res[c] = 1'b0;
    return res;
  endfunction

  // Model: events complete after the latency chosen by the stimulus (0 = dropped)
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      foreach (held[i]) held[i] = 1'b0;
      q.delete();
      exp_rst = 1'b0;
      exp_ovr = 1'b0;
    end else begin
      exp_rst = 1'b0;
      foreach (q[i])
        if (q[i].due - 1 == cyc && !q[i].rel && q[i].key[7:0] == 8'h71 &&
            (held[9'h014] | held[9'h114]) && (held[9'h011] | held[9'h111]))
          exp_rst = 1'b1;
      while (q.size() > 0 && q[0].due == cyc) begin
        if (!q[0].rel && q[0].key == 9'h0AA) foreach (held[i]) held[i] = 1'b0;
        else held[q[0].key] = !q[0].rel;
        void'(q.pop_front());
      end
      exp_ovr = kb_interrupt && (tx_lat == 0);
      if (kb_interrupt && tx_lat != 0)
        q.push_back('{key: {extended, scancode}, rel: released, due: cyc + tx_lat});
    end
  end

  task automatic cmp(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("keycol", int'(keycol), int'(rst_n ? model_keycol(addr) : 5'h1F));
    cmp("kbd_reset_req", int'(kbd_reset_req), int'(rst_n && exp_rst));
    cmp("overrun", int'(overrun), int'(rst_n && exp_ovr));
    if (kbd_reset_req) n_rst_seen++;
    if (overrun) n_ovr_seen++;
    if (lit_en) begin
      case (lit_sel)
        0:       cmp(lit_name, int'(keycol), lit_exp);
        1:       cmp(lit_name, n_rst_seen, lit_exp);
        default: cmp(lit_name, n_ovr_seen, lit_exp);
      endcase
    end
  end

  task automatic lit(input string nm, input int sel, input int exp);
    lit_name = nm;
    lit_sel  = sel;
    lit_exp  = exp;
    lit_en   = 1'b1;
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  task automatic set_addr(input logic [7:0] a);
    @(posedge clk);
    #1 addr = a;
  endtask

  task automatic send(input logic [8:0] key, input logic rel, input int lat);
    @(posedge clk);
    #1;
    scancode     = key[7:0];
    extended     = key[8];
    released     = rel;
    tx_lat       = lat;
    kb_interrupt = 1'b1;
    @(posedge clk);
    #1 kb_interrupt = 1'b0;
  endtask

  task automatic sendw(input logic [8:0] key, input logic rel);
    send(key, rel, 2);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; kb_interrupt = 1'b0; scancode = 8'h00; released = 1'b0;
    extended = 1'b0; addr = 8'h00; tx_lat = 2; lit_en = 1'b0; lit_sel = 0;
    lit_exp = 0; lit_name = "";

    // reset state
    lit("rst_addr00", 0, 5'h1F);
    set_addr(8'hFE);
    lit("rst_addrFE", 0, 5'h1F);
    @(posedge clk); #1 rst_n = 1'b1;
    set_addr(8'h00);
    lit("post_reset", 0, 5'h1F);

    // single key, latency, row select, break, unmapped, idempotent makes
    set_addr(8'hFD);
    send(9'h01C, 1'b0, 2);
    lit("lat_T0", 0, 5'h1F);
    lit("lat_T1", 0, 5'h1F);
    lit("lat_T2", 0, 5'h1E);
    set_addr(8'hFE);
    lit("a_other_row", 0, 5'h1F);
    sendw(9'h01C, 1'b1);
    set_addr(8'hFD);
    lit("a_break", 0, 5'h1F);
    sendw(9'h076, 1'b0);
    sendw(9'h01B, 1'b1);
    set_addr(8'h00);
    lit("unmapped", 0, 5'h1F);
    sendw(9'h01C, 1'b0);
    sendw(9'h01C, 1'b0);
    sendw(9'h01C, 1'b1);
    lit("idempotent", 0, 5'h1F);

    // CS sources: shift plus cursor-up composite, backspace
    sendw(9'h012, 1'b0);
    sendw(9'h175, 1'b0);
    set_addr(8'hFE);
    lit("cs_two_src", 0, 5'h1E);
    set_addr(8'hEF);
    lit("up_is_7", 0, 5'h17);
    sendw(9'h175, 1'b1);
    lit("up_released", 0, 5'h1F);
    set_addr(8'hFE);
    lit("cs_kept", 0, 5'h1E);
    sendw(9'h012, 1'b1);
    lit("cs_cleared", 0, 5'h1F);
    sendw(9'h066, 1'b0);
    set_addr(8'hEF);
    lit("bksp_0", 0, 5'h1E);
    sendw(9'h066, 1'b1);

    // all rows / no rows
    sendw(9'h01C, 1'b0);
    sendw(9'h015, 1'b0);
    set_addr(8'h00);
    lit("all_rows", 0, 5'h1E);
    set_addr(8'hFF);
    lit("no_rows", 0, 5'h1F);
    sendw(9'h01C, 1'b1);
    sendw(9'h015, 1'b1);

    // Ctrl+Alt+Del, then BAT clear
    sendw(9'h014, 1'b0);
    sendw(9'h011, 1'b0);
    sendw(9'h171, 1'b0);
    lit("del_pulses", 1, 1);
    set_addr(8'h00);
    lit("ss_only", 0, 5'h1D);
    sendw(9'h0AA, 1'b0);
    lit("bat_clear", 0, 5'h1F);
    sendw(9'h171, 1'b0);
    lit("del_no_mods", 1, 1);

    // back-to-back events: A applied, S pended, D dropped
    set_addr(8'hFD);
    @(posedge clk); #1;
    scancode = 8'h1C; extended = 1'b0; released = 1'b0; tx_lat = 2; kb_interrupt = 1'b1;
    @(posedge clk); #1;
    scancode = 8'h1B; tx_lat = 4;
    @(posedge clk); #1;
    scancode = 8'h23; tx_lat = 0;
    @(posedge clk); #1;
    kb_interrupt = 1'b0; tx_lat = 2;
    repeat (6) @(posedge clk);
    lit("burst_AS", 0, 5'h1C);
    lit("ovr_pulses", 2, 1);

    // reset while in LOOKUP discards the event
    send(9'h02A, 1'b0, 2);
    rst_n = 1'b0;
    lit("rst_lookup", 0, 5'h1F);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_addr(8'h00);
    repeat (5) @(posedge clk);
    lit("rst_dropped", 0, 5'h1F);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
